hazard_ctrl: RTL and testbench

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/hazard_pkg.sv | 26 ++
 rtl/fwd_unit.sv | 41 ++++
 rtl/hazard_ctrl.sv | 240 ++++++++++++++++++++++++
 tb/tb_hazard_ctrl.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
`default_nettype none
// ============================================================================
// Module   : hazard_pkg
// Purpose  : Shared types and constants for the pipeline hazard controller.
//            - state_t   : controller FSM states (RUN, MEMWAIT)
//            - fwd_sel_t : ALU operand source select
//            - REG_AW    : register-file address width
// Revision : 1.0 - initial release
// ============================================================================
package hazard_pkg;

    localparam int REG_AW = 5;

    typedef enum logic [0:0] {
        RUN     = 1'b0,
        MEMWAIT = 1'b1
    } state_t;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_MEM = 2'b01,
        FWD_WB  = 2'b10
    } fwd_sel_t;

endpackage : hazard_pkg
`default_nettype wire

// File: rtl/fwd_unit.sv
`default_nettype none
// ============================================================================
// Module   : fwd_unit
// Purpose  : Compare one source register against the MEM and WB destinations
//            and select the freshest producer. MEM beats WB; x0 never matches.
// Ports    : rs          in  REG_AW  source register being resolved
//            rd_mem      in  REG_AW  destination in MEM
//            regwen_mem  in  1       MEM writes the register file
//            rd_wb       in  REG_AW  destination in WB
//            regwen_wb   in  1       WB writes the register file
//            sel         out 2       FWD_RF / FWD_MEM / FWD_WB
// Revision : 1.0 - initial release
// ============================================================================
module fwd_unit
    import hazard_pkg::*;
(
    input  logic [REG_AW-1:0] rs,
    input  logic [REG_AW-1:0] rd_mem,
    input  logic              regwen_mem,
    input  logic [REG_AW-1:0] rd_wb,
    input  logic              regwen_wb,
    output fwd_sel_t          sel
);

    logic w_mem_hit;
    logic w_wb_hit;

    assign w_mem_hit = regwen_mem && (rd_mem != '0) && (rd_mem == rs);
    assign w_wb_hit  = regwen_wb  && (rd_wb  != '0) && (rd_wb  == rs);

    always_comb begin
        sel = FWD_RF;
        if (w_mem_hit) begin
            sel = FWD_MEM;
        end else if (w_wb_hit) begin
            sel = FWD_WB;
        end
    end

endmodule : fwd_unit
`default_nettype wire

// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : hazard_ctrl
// Purpose  : Hazard control for a 5-stage pipeline: operand forwarding,
//            load-use stall, branch flush, data-memory wait with watchdog
//            abort, and optional stall/flush performance counters.
// Config   : HAZARD_PERF_EN - when defined, stallcnt/flushcnt count; when
//            undefined the ports are tied to zero and no counter flops exist.
// Ports    : clk, rstn (synchronous, active-low)
//            rs1_id, rs2_id, rs1_ex, rs2_ex, rd_ex, memread_ex
//            rd_mem, rd_wb, regwen_mem, regwen_wb, memwrite_mem, rs2_mem
//            brtaken_ex, dmem_req_mem, dmem_ready
//            fwda_ex, fwdb_ex (2b), fwdls
//            stall_if/id/ex/mem, flush_id/ex, mem_err
//            stallcnt, flushcnt (CNT_W)
// Revision : 1.0 - initial release
// ============================================================================
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 32
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [REG_AW-1:0] rs1_id,
    input  logic [REG_AW-1:0] rs2_id,
    input  logic [REG_AW-1:0] rs1_ex,
    input  logic [REG_AW-1:0] rs2_ex,
    input  logic [REG_AW-1:0] rd_ex,
    input  logic              memread_ex,
    input  logic [REG_AW-1:0] rd_mem,
    input  logic [REG_AW-1:0] rd_wb,
    input  logic              regwen_mem,
    input  logic              regwen_wb,
    input  logic              memwrite_mem,
    input  logic [REG_AW-1:0] rs2_mem,
    input  logic              brtaken_ex,
    input  logic              dmem_req_mem,
    input  logic              dmem_ready,
    output logic [1:0]        fwda_ex,
    output logic [1:0]        fwdb_ex,
    output logic              fwdls,
    output logic              stall_if,
    output logic              stall_id,
    output logic              stall_ex,
    output logic              stall_mem,
    output logic              flush_id,
    output logic              flush_ex,
    output logic              mem_err,
    output logic [CNT_W-1:0]  stallcnt,
    output logic [CNT_W-1:0]  flushcnt
);

    localparam int                WD_W      = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WD_W-1:0]   C_WD_LAST = WD_W'(TIMEOUT - 1);

    state_t          r_state;
    state_t          w_state_next;
    logic [WD_W-1:0] r_wdog;
    logic            r_fwdls_hold;

    fwd_sel_t        w_fwda;
    fwd_sel_t        w_fwdb;
    fwd_sel_t        w_fwds;
    logic            w_fwdls_raw;
    logic            w_loaduse;

    // ------------------------------------------------------------------
    // Forwarding
    // ------------------------------------------------------------------
    fwd_unit u_fwd_a (
        .rs         (rs1_ex),
        .rd_mem     (rd_mem),
        .regwen_mem (regwen_mem),
        .rd_wb      (rd_wb),
        .regwen_wb  (regwen_wb),
        .sel        (w_fwda)
    );

    fwd_unit u_fwd_b (
        .rs         (rs2_ex),
        .rd_mem     (rd_mem),
        .regwen_mem (regwen_mem),
        .rd_wb      (rd_wb),
        .regwen_wb  (regwen_wb),
        .sel        (w_fwdb)
    );

    // Store data in MEM can only be overtaken by the WB result, so the MEM
    // comparison path of this instance is tied off.
    fwd_unit u_fwd_ls (
        .rs         (rs2_mem),
        .rd_mem     ('0),
        .regwen_mem (1'b0),
        .rd_wb      (rd_wb),
        .regwen_wb  (regwen_wb),
        .sel        (w_fwds)
    );

    assign fwda_ex     = w_fwda;
    assign fwdb_ex     = w_fwdb;
    assign w_fwdls_raw = memwrite_mem && (w_fwds == FWD_WB);

    assign w_loaduse = memread_ex && (rd_ex != '0) &&
                       ((rd_ex == rs1_id) || (rd_ex == rs2_id));

    // ------------------------------------------------------------------
    // FSM state register, watchdog and held store-forward select
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state      <= RUN;
            r_wdog       <= '0;
            r_fwdls_hold <= 1'b0;
        end else begin
            r_state <= w_state_next;
            // Held at zero in RUN so the count starts cleared on entry.
            if (r_state == MEMWAIT) begin
                r_wdog <= r_wdog + 1'b1;
            end else begin
                r_wdog <= '0;
            end
            if ((r_state == RUN) && (w_state_next == MEMWAIT)) begin
                r_fwdls_hold <= w_fwdls_raw;
            end
        end
    end

    // ------------------------------------------------------------------
    // Next state and control outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        stall_if     = 1'b0;
        stall_id     = 1'b0;
        stall_ex     = 1'b0;
        stall_mem    = 1'b0;
        flush_id     = 1'b0;
        flush_ex     = 1'b0;
        mem_err      = 1'b0;
        fwdls        = w_fwdls_raw;

        case (r_state)
            RUN: begin
                if (dmem_req_mem && !dmem_ready) begin
                    // The entry cycle already freezes the whole pipeline so
                    // the access in MEM is not lost.
                    w_state_next = MEMWAIT;
                    stall_if     = 1'b1;
                    stall_id     = 1'b1;
                    stall_ex     = 1'b1;
                    stall_mem    = 1'b1;
                end else if (brtaken_ex) begin
                    // A taken branch squashes the load-use victim anyway,
                    // so no stall is needed alongside the flush.
                    flush_id = 1'b1;
                    flush_ex = 1'b1;
                end else if (w_loaduse) begin
                    stall_if = 1'b1;
                    stall_id = 1'b1;
                    flush_ex = 1'b1;
                end
            end

            MEMWAIT: begin
                fwdls = r_fwdls_hold;
                if (dmem_ready) begin
                    // Completion cycle: the pipeline advances, so a branch
                    // that was held in EX by the stall is acted on now.
                    w_state_next = RUN;
                    if (brtaken_ex) begin
                        flush_id = 1'b1;
                        flush_ex = 1'b1;
                    end else if (w_loaduse) begin
                        stall_if = 1'b1;
                        stall_id = 1'b1;
                        flush_ex = 1'b1;
                    end
                end else begin
                    stall_if  = 1'b1;
                    stall_id  = 1'b1;
                    stall_ex  = 1'b1;
                    stall_mem = 1'b1;
                    if (r_wdog == C_WD_LAST) begin
                        mem_err      = 1'b1;
                        w_state_next = RUN;
                    end
                end
            end

            default: begin
                w_state_next = RUN;
            end
        endcase

        // Control outputs are quiet while reset is applied.
        if (!rstn) begin
            w_state_next = RUN;
            stall_if     = 1'b0;
            stall_id     = 1'b0;
            stall_ex     = 1'b0;
            stall_mem    = 1'b0;
            flush_id     = 1'b0;
            flush_ex     = 1'b0;
            mem_err      = 1'b0;
            fwdls        = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Performance counters
    // ------------------------------------------------------------------
`ifdef HAZARD_PERF_EN
    logic [CNT_W-1:0] r_stallcnt;
    logic [CNT_W-1:0] r_flushcnt;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_stallcnt <= '0;
            r_flushcnt <= '0;
        end else begin
            if (stall_if) begin
                r_stallcnt <= r_stallcnt + 1'b1;
            end
            if (flush_id) begin
                r_flushcnt <= r_flushcnt + 1'b1;
            end
        end
    end

    assign stallcnt = r_stallcnt;
    assign flushcnt = r_flushcnt;
`else
    assign stallcnt = '0;
    assign flushcnt = '0;
`endif

endmodule : hazard_ctrl
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_hazard_ctrl
// Purpose  : Directed self-checking bench for hazard_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hazard_ctrl;

`ifdef HAZARD_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rstn;
    logic [4:0]  rs1_id, rs2_id, rs1_ex, rs2_ex, rd_ex, rd_mem, rd_wb, rs2_mem;
    logic        memread_ex, regwen_mem, regwen_wb, memwrite_mem;
    logic        brtaken_ex, dmem_req_mem, dmem_ready;
    logic [1:0]  fwda_ex, fwdb_ex;
    logic        fwdls, stall_if, stall_id, stall_ex, stall_mem;
    logic        flush_id, flush_ex, mem_err;
    logic [31:0] stallcnt, flushcnt;
    logic [6:0]  ctl;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_stall = 0;
    int exp_flush = 0;

    always #5 clk = ~clk;

    assign ctl = {stall_if, stall_id, stall_ex, stall_mem, flush_id, flush_ex, mem_err};

    hazard_ctrl #(.TIMEOUT(16), .CNT_W(32)) dut (
        .clk          (clk),
        .rstn         (rstn),
        .rs1_id       (rs1_id),
        .rs2_id       (rs2_id),
        .rs1_ex       (rs1_ex),
        .rs2_ex       (rs2_ex),
        .rd_ex        (rd_ex),
        .memread_ex   (memread_ex),
        .rd_mem       (rd_mem),
        .rd_wb        (rd_wb),
        .regwen_mem   (regwen_mem),
        .regwen_wb    (regwen_wb),
        .memwrite_mem (memwrite_mem),
        .rs2_mem      (rs2_mem),
        .brtaken_ex   (brtaken_ex),
        .dmem_req_mem (dmem_req_mem),
        .dmem_ready   (dmem_ready),
        .fwda_ex      (fwda_ex),
        .fwdb_ex      (fwdb_ex),
        .fwdls        (fwdls),
        .stall_if     (stall_if),
        .stall_id     (stall_id),
        .stall_ex     (stall_ex),
        .stall_mem    (stall_mem),
        .flush_id     (flush_id),
        .flush_ex     (flush_ex),
        .mem_err      (mem_err),
        .stallcnt     (stallcnt),
        .flushcnt     (flushcnt)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rs1_id = 0; rs2_id = 0; rs1_ex = 0; rs2_ex = 0; rd_ex = 0;
        rd_mem = 0; rd_wb = 0; rs2_mem = 0;
        memread_ex = 0; regwen_mem = 0; regwen_wb = 0; memwrite_mem = 0;
        brtaken_ex = 0; dmem_req_mem = 0; dmem_ready = 0;
    endtask

    task automatic test_reset();
        idle();
        rstn = 1'b0;
        tick();
        tick();
        n_checks++; if (ctl !== 7'b0) begin n_fail++; $display("FAIL reset_ctl got %b want %b", ctl, 7'b0); end
        n_checks++; if ({fwda_ex, fwdb_ex, fwdls} !== 5'b0) begin n_fail++; $display("FAIL reset_fwd got %b want %b", {fwda_ex, fwdb_ex, fwdls}, 5'b0); end
        n_checks++; if ({stallcnt, flushcnt} !== 64'd0) begin n_fail++; $display("FAIL reset_cnt got %0d/%0d want 0/0", stallcnt, flushcnt); end
        rstn = 1'b1;
        tick();
        n_checks++; if (ctl !== 7'b0) begin n_fail++; $display("FAIL reset_release_ctl got %b want %b", ctl, 7'b0); end
    endtask

    task automatic test_forwarding();
        idle();
        rd_mem = 5; rd_wb = 5; regwen_mem = 1; regwen_wb = 1; rs1_ex = 5; rs2_ex = 5;
        #1;
        n_checks++; if (fwda_ex !== 2'b01) begin n_fail++; $display("FAIL fwda_mem got %b want 01", fwda_ex); end
        n_checks++; if (fwdb_ex !== 2'b01) begin n_fail++; $display("FAIL fwdb_mem got %b want 01", fwdb_ex); end
        regwen_mem = 0;
        #1;
        n_checks++; if (fwda_ex !== 2'b10) begin n_fail++; $display("FAIL fwda_wb got %b want 10", fwda_ex); end
        rs1_ex = 0;
        #1;
        n_checks++; if (fwda_ex !== 2'b00) begin n_fail++; $display("FAIL fwda_rf got %b want 00", fwda_ex); end
        rd_mem = 0; rd_wb = 0; regwen_mem = 1; rs2_ex = 0;
        #1;
        n_checks++; if ({fwda_ex, fwdb_ex} !== 4'b0000) begin n_fail++; $display("FAIL fwd_x0 got %b want 0000", {fwda_ex, fwdb_ex}); end
        rd_mem = 6; rd_wb = 6; regwen_mem = 0; regwen_wb = 1; rs2_ex = 6;
        #1;
        n_checks++; if (fwdb_ex !== 2'b10) begin n_fail++; $display("FAIL fwdb_wb got %b want 10", fwdb_ex); end
        memwrite_mem = 1; rd_wb = 9; rs2_mem = 9;
        #1;
        n_checks++; if (fwdls !== 1'b1) begin n_fail++; $display("FAIL fwdls_hit got %b want 1", fwdls); end
        memwrite_mem = 0;
        #1;
        n_checks++; if (fwdls !== 1'b0) begin n_fail++; $display("FAIL fwdls_nostore got %b want 0", fwdls); end
        memwrite_mem = 1; rs2_mem = 0; rd_wb = 0;
        #1;
        n_checks++; if (fwdls !== 1'b0) begin n_fail++; $display("FAIL fwdls_x0 got %b want 0", fwdls); end
        n_checks++; if (ctl !== 7'b0) begin n_fail++; $display("FAIL fwd_ctl got %b want %b", ctl, 7'b0); end
        idle();
        tick();
    endtask

    task automatic test_load_use();
        idle();
        memread_ex = 1; rd_ex = 7; rs2_id = 7;
        #1;
        n_checks++; if (ctl !== 7'b1100010) begin n_fail++; $display("FAIL loaduse_ctl got %b want %b", ctl, 7'b1100010); end
        tick();
        memread_ex = 0;
        #1;
        n_checks++; if (ctl !== 7'b0) begin n_fail++; $display("FAIL loaduse_after got %b want %b", ctl, 7'b0); end
        exp_stall += 1;
        n_checks++; if (stallcnt !== (PERF ? 32'(exp_stall) : 32'd0)) begin n_fail++; $display("FAIL loaduse_stallcnt got %0d want %0d", stallcnt, PERF ? exp_stall : 0); end
        memread_ex = 1; rd_ex = 0; rs1_id = 0; rs2_id = 0;
        #1;
        n_checks++; if (ctl !== 7'b0) begin n_fail++; $display("FAIL loaduse_x0 got %b want %b", ctl, 7'b0); end
        idle();
        tick();
    endtask

    task automatic test_memwait();
        idle();
        memwrite_mem = 1; regwen_wb = 1; rd_wb = 3; rs2_mem = 3;
        dmem_req_mem = 1; dmem_ready = 0;
        #1;
        n_checks++; if ({ctl, fwdls} !== 8'b1111000_1) begin n_fail++; $display("FAIL memwait_entry got %b want %b", {ctl, fwdls}, 8'b11110001); end
        tick();
        rd_wb = 4;
        for (int k = 1; k <= 2; k++) begin
            #1;
            n_checks++; if ({ctl, fwdls} !== 8'b1111000_1) begin n_fail++; $display("FAIL memwait_c%0d got %b want %b", k, {ctl, fwdls}, 8'b11110001); end
            tick();
        end
        dmem_ready = 1;
        #1;
        n_checks++; if ({ctl, fwdls} !== 8'b0000000_1) begin n_fail++; $display("FAIL memwait_ready got %b want %b", {ctl, fwdls}, 8'b00000001); end
        tick();
        dmem_req_mem = 0; dmem_ready = 0;
        #1;
        n_checks++; if ({ctl, fwdls} !== 8'b0) begin n_fail++; $display("FAIL memwait_run got %b want %b", {ctl, fwdls}, 8'b0); end
        exp_stall += 3;
        n_checks++; if (stallcnt !== (PERF ? 32'(exp_stall) : 32'd0)) begin n_fail++; $display("FAIL memwait_stallcnt got %0d want %0d", stallcnt, PERF ? exp_stall : 0); end
        idle();
    endtask

    task automatic test_timeout();
        idle();
        dmem_req_mem = 1;
        #1;
        n_checks++; if (ctl !== 7'b1111000) begin n_fail++; $display("FAIL timeout_entry got %b want %b", ctl, 7'b1111000); end
        tick();
        for (int k = 1; k <= 16; k++) begin
            if (k == 16) dmem_req_mem = 0;
            #1;
            n_checks++;
            if (ctl !== ((k == 16) ? 7'b1111001 : 7'b1111000)) begin
                n_fail++;
                $display("FAIL timeout_c%0d got %b want %b", k, ctl, (k == 16) ? 7'b1111001 : 7'b1111000);
            end
            tick();
        end
        #1;
        n_checks++; if (ctl !== 7'b0) begin n_fail++; $display("FAIL timeout_run got %b want %b", ctl, 7'b0); end
        exp_stall += 17;
        n_checks++; if (stallcnt !== (PERF ? 32'(exp_stall) : 32'd0)) begin n_fail++; $display("FAIL timeout_stallcnt got %0d want %0d", stallcnt, PERF ? exp_stall : 0); end
        idle();
    endtask

    task automatic test_branch();
        idle();
        brtaken_ex = 1;
        #1;
        n_checks++; if (ctl !== 7'b0000110) begin n_fail++; $display("FAIL branch_ctl got %b want %b", ctl, 7'b0000110); end
        tick();
        memread_ex = 1; rd_ex = 7; rs1_id = 7;
        #1;
        n_checks++; if (ctl !== 7'b0000110) begin n_fail++; $display("FAIL branch_loaduse got %b want %b", ctl, 7'b0000110); end
        tick();
        brtaken_ex = 0;
        #1;
        n_checks++; if (ctl !== 7'b1100010) begin n_fail++; $display("FAIL loaduse_rs1 got %b want %b", ctl, 7'b1100010); end
        tick();
        idle();
        #1;
        exp_stall += 1;
        exp_flush += 2;
        n_checks++; if (stallcnt !== (PERF ? 32'(exp_stall) : 32'd0)) begin n_fail++; $display("FAIL branch_stallcnt got %0d want %0d", stallcnt, PERF ? exp_stall : 0); end
        n_checks++; if (flushcnt !== (PERF ? 32'(exp_flush) : 32'd0)) begin n_fail++; $display("FAIL branch_flushcnt got %0d want %0d", flushcnt, PERF ? exp_flush : 0); end
    endtask

    task automatic test_branch_in_wait();
        idle();
        dmem_req_mem = 1; brtaken_ex = 1;
        #1;
        n_checks++; if (ctl !== 7'b1111000) begin n_fail++; $display("FAIL brwait_entry got %b want %b", ctl, 7'b1111000); end
        tick();
        #1;
        n_checks++; if (ctl !== 7'b1111000) begin n_fail++; $display("FAIL brwait_c1 got %b want %b", ctl, 7'b1111000); end
        tick();
        dmem_ready = 1;
        #1;
        n_checks++; if (ctl !== 7'b0000110) begin n_fail++; $display("FAIL brwait_release got %b want %b", ctl, 7'b0000110); end
        tick();
        idle();
        #1;
        n_checks++; if (ctl !== 7'b0) begin n_fail++; $display("FAIL brwait_run got %b want %b", ctl, 7'b0); end
        exp_stall += 2;
        exp_flush += 1;
        n_checks++; if (stallcnt !== (PERF ? 32'(exp_stall) : 32'd0)) begin n_fail++; $display("FAIL brwait_stallcnt got %0d want %0d", stallcnt, PERF ? exp_stall : 0); end
        n_checks++; if (flushcnt !== (PERF ? 32'(exp_flush) : 32'd0)) begin n_fail++; $display("FAIL brwait_flushcnt got %0d want %0d", flushcnt, PERF ? exp_flush : 0); end
    endtask

    task automatic test_reset_in_wait();
        int errs;
        idle();
        dmem_req_mem = 1;
        #1;
        n_checks++; if (ctl !== 7'b1111000) begin n_fail++; $display("FAIL rstwait_entry got %b want %b", ctl, 7'b1111000); end
        tick();
        #1;
        n_checks++; if (ctl !== 7'b1111000) begin n_fail++; $display("FAIL rstwait_c1 got %b want %b", ctl, 7'b1111000); end
        tick();
        rstn = 1'b0;
        #1;
        n_checks++; if (ctl !== 7'b0) begin n_fail++; $display("FAIL rstwait_inreset got %b want %b", ctl, 7'b0); end
        tick();
        rstn = 1'b1;
        dmem_req_mem = 0;
        #1;
        exp_stall = 0;
        exp_flush = 0;
        n_checks++; if ({ctl, fwdls} !== 8'b0) begin n_fail++; $display("FAIL rstwait_run got %b want %b", {ctl, fwdls}, 8'b0); end
        n_checks++; if ({stallcnt, flushcnt} !== 64'd0) begin n_fail++; $display("FAIL rstwait_cnt got %0d/%0d want 0/0", stallcnt, flushcnt); end
        errs = 0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (ctl !== 7'b0) errs++;
        end
        n_checks++; if (errs !== 0) begin n_fail++; $display("FAIL rstwait_quiet got %0d bad cycles want 0", errs); end
    endtask

    initial begin
        idle();
        rstn = 1'b0;
        test_reset();
        test_forwarding();
        test_load_use();
        test_memwait();
        test_timeout();
        test_branch();
        test_branch_in_wait();
        test_reset_in_wait();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_hazard_ctrl
`default_nettype wire
